// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: state encoding and default widths.

package mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MEM_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StWait = ST_WAIT,
    StResp = ST_RESP
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Byte-wide storage: synchronous write, combinational read, no reset.

module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Responder end of the CPU memory request interface: one outstanding request,
// a programmable number of wait states, valid/ready on request and response.

module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = MEM_ADDR_W,
  parameter int unsigned DATA_W      = MEM_DATA_W,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              rsp_ready
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              active_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_fire;
  logic              commit;
  logic              in_range;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  assign in_range = 32'(addr_q) < DEPTH;
  assign req_fire = (state_q == StIdle) && active_q && req_valid;
  // The transaction is performed on the edge that leaves WAIT.
  assign commit   = (state_q == StWait) && (cnt_q == 4'd0);
  assign arr_we   = commit && we_q && in_range;

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IdxW)
  ) u_mem_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (addr_q[IdxW-1:0]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = active_q;
        if (req_fire) begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      StWait: begin
        if (commit) begin
          state_d = StResp;
          rdata_d = (!we_q && in_range) ? arr_rdata : '0;
          err_d   = !in_range;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      active_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= 1'b1;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (req_fire) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and 128 words,
// one with zero wait states and 256 words.

module tb_mem_responder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_z;
  logic       a_req_valid, a_req_we, a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_ready;
  logic [7:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic       z_req_valid, z_req_we, z_req_ready, z_rsp_valid, z_rsp_err, z_rsp_ready;
  logic [7:0] z_req_addr, z_req_wdata, z_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .DEPTH       (128),
    .WAIT_CYCLES (2)
  ) u_dut_a (
    .clk       (clk),
    .reset_n   (rst_a),
    .req_valid (a_req_valid),
    .req_we    (a_req_we),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .req_ready (a_req_ready),
    .rsp_valid (a_rsp_valid),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err),
    .rsp_ready (a_rsp_ready)
  );

  mem_responder #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .DEPTH       (256),
    .WAIT_CYCLES (0)
  ) u_dut_z (
    .clk       (clk),
    .reset_n   (rst_z),
    .req_valid (z_req_valid),
    .req_we    (z_req_we),
    .req_addr  (z_req_addr),
    .req_wdata (z_req_wdata),
    .req_ready (z_req_ready),
    .rsp_valid (z_rsp_valid),
    .rsp_rdata (z_rsp_rdata),
    .rsp_err   (z_rsp_err),
    .rsp_ready (z_rsp_ready)
  );

  // Issues one request, counts edges from acceptance to rsp_valid, then completes the
  // response handshake (rsp_ready must be high). lat = 40 means no response arrived.
  task automatic do_req(input bit z, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, output int lat, output logic [7:0] rdata,
                        output logic err);
    if (z) begin
      z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_wdata = wdata;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    z_req_valid = 1'b0;
    lat = 0;
    while (!(z ? z_rsp_valid : a_rsp_valid) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = z ? z_rsp_rdata : a_rsp_rdata;
    err   = z ? z_rsp_err : a_rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    rst_z = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({a_rsp_valid, a_rsp_err, a_rsp_rdata, a_req_ready} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_a: got v=%b e=%b d=%h rdy=%b required all 0",
                 a_rsp_valid, a_rsp_err, a_rsp_rdata, a_req_ready);
      end
      n_checks++;
      if ({z_rsp_valid, z_rsp_err, z_rsp_rdata, z_req_ready} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_z: got v=%b e=%b d=%h rdy=%b required all 0",
                 z_rsp_valid, z_rsp_err, z_rsp_rdata, z_req_ready);
      end
    end
    rst_a = 1'b1;
    rst_z = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (a_req_ready !== 1'b1 || z_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got a=%b z=%b required 1", a_req_ready, z_req_ready);
    end
  endtask

  task automatic test_store_load();
    int lat; logic [7:0] d; logic e;
    do_req(1'b0, 1'b1, 8'h10, 8'hA5, lat, d, e);
    n_checks++;
    if (lat !== 3 || d !== 8'h00 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL store_10: got lat=%0d d=%h e=%b required lat=3 d=00 e=0", lat, d, e);
    end
    n_checks++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL store_10_idle: got rdy=%b v=%b required 1 0", a_req_ready, a_rsp_valid);
    end
    do_req(1'b0, 1'b0, 8'h10, 8'h00, lat, d, e);
    n_checks++;
    if (lat !== 3 || d !== 8'hA5 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL load_10: got lat=%0d d=%h e=%b required lat=3 d=a5 e=0", lat, d, e);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [7:0] d; logic e;
    do_req(1'b0, 1'b1, 8'h90, 8'h33, lat, d, e);
    n_checks++;
    if (lat !== 3 || d !== 8'h00 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_store: got lat=%0d d=%h e=%b required lat=3 d=00 e=1", lat, d, e);
    end
    do_req(1'b0, 1'b0, 8'h90, 8'h00, lat, d, e);
    n_checks++;
    if (d !== 8'h00 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_load: got d=%h e=%b required d=00 e=1", d, e);
    end
    n_checks++;
    if (a_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_err_clear: got %b required 0", a_rsp_err);
    end
    do_req(1'b0, 1'b0, 8'h10, 8'h00, lat, d, e);
    n_checks++;
    if (d !== 8'hA5 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_followup: got d=%h e=%b required d=a5 e=0", d, e);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] d; logic e;
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'h10;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d required 3", lat);
    end
    // Competing stores to the same address must be ignored while the response is held.
    a_req_we = 1'b1; a_req_addr = 8'h10; a_req_wdata = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      a_req_valid = ~a_req_valid;
      @(posedge clk); #1;
      n_checks++;
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 8'hA5 || a_req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h rdy=%b required 1 a5 0",
                 i, a_rsp_valid, a_rsp_rdata, a_req_ready);
      end
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_rsp_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b rdy=%b d=%h required 0 1 00",
               a_rsp_valid, a_req_ready, a_rsp_rdata);
    end
    do_req(1'b0, 1'b0, 8'h10, 8'h00, lat, d, e);
    n_checks++;
    if (d !== 8'hA5) begin
      n_fail++;
      $display("FAIL bp_no_store: got %h required a5", d);
    end
  endtask

  task automatic test_zero_wait();
    int lat; logic [7:0] d; logic e;
    do_req(1'b1, 1'b1, 8'h00, 8'h5A, lat, d, e);
    n_checks++;
    if (lat !== 1 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_store: got lat=%0d e=%b required lat=1 e=0", lat, e);
    end
    do_req(1'b1, 1'b0, 8'h00, 8'h00, lat, d, e);
    n_checks++;
    if (lat !== 1 || d !== 8'h5A || e !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_load: got lat=%0d d=%h e=%b required lat=1 d=5a e=0", lat, d, e);
    end
    n_checks++;
    if (z_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zw_idle: got %b required 1", z_req_ready);
    end
  endtask

  task automatic test_mid_reset();
    int lat; logic [7:0] d; logic e;
    do_req(1'b0, 1'b1, 8'h20, 8'h11, lat, d, e);
    // Hold a read response, then reset between clock edges.
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'h20;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 8'h11) begin
      n_fail++;
      $display("FAIL mr_pre: got v=%b d=%h required 1 11", a_rsp_valid, a_rsp_rdata);
    end
    #2 rst_a = 1'b0;
    #1;
    n_checks++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 8'h00 || a_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_async_resp: got v=%b d=%h rdy=%b required 0 00 0",
               a_rsp_valid, a_rsp_rdata, a_req_ready);
    end
    @(posedge clk); #1;
    rst_a = 1'b1;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    // Store of 0xFF aborted while still waiting.
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 8'h20; a_req_wdata = 8'hFF;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b0;
    #1;
    n_checks++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0 || a_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_async_wait: got v=%b rdy=%b e=%b required 0 0 0",
               a_rsp_valid, a_req_ready, a_rsp_err);
    end
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 1'b0, 8'h20, 8'h00, lat, d, e);
    n_checks++;
    if (d !== 8'h11 || e !== 1'b0 || lat !== 3) begin
      n_fail++;
      $display("FAIL mr_readback: got d=%h e=%b lat=%0d required 11 0 3", d, e, lat);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_z = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_out_of_range();
    test_backpressure();
    test_zero_wait();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
